// File: rtl/bf_io_port.sv
// Byte-stream I/O port for the bf core: an output FIFO drained by the host and
// an input FIFO that serves the core's ',' requests one byte per request.
module bf_io_port #(
   parameter int         DEPTH    = 4,
   parameter int         AW       = 2,
   parameter logic [7:0] EOF_BYTE = 8'hFF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          core_out_valid,
   input  logic [7:0]    core_out_data,
   output logic          core_out_ready,
   input  logic          core_in_req,
   output logic          core_in_valid,
   output logic [7:0]    core_in_data,
   output logic          host_tx_valid,
   output logic [7:0]    host_tx_data,
   input  logic          host_tx_ready,
   input  logic          host_rx_valid,
   input  logic [7:0]    host_rx_data,
   output logic          host_rx_ready,
   input  logic          host_eof,
   output logic [AW:0]   out_count,
   output logic [AW:0]   in_count
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   logic [7:0]    out_mem [0:DEPTH-1];
   logic [7:0]    in_mem  [0:DEPTH-1];
   logic [AW-1:0] out_wr, out_rd;
   logic [AW-1:0] in_wr, in_rd;
   logic [1:0]    state;

   logic out_push, out_pop, in_push, in_pop, in_eof_load;

   // Ready depends only on the current count, so a full FIFO refuses a push
   // even when a pop happens in the same cycle.
   assign core_out_ready = (out_count != FULL);
   assign host_tx_valid  = (out_count != '0);
   assign host_tx_data   = out_mem[out_rd];
   assign host_rx_ready  = (in_count != FULL);

   assign out_push    = core_out_valid && core_out_ready;
   assign out_pop     = host_tx_valid && host_tx_ready;
   assign in_push     = host_rx_valid && host_rx_ready;
   assign in_pop      = (state == S_IDLE) && core_in_req && (in_count != '0);
   assign in_eof_load = (state == S_IDLE) && core_in_req && (in_count == '0) && host_eof;

   assign core_in_valid = (state == S_GRANT);

   always_ff @(posedge clk) begin
      if (out_push) out_mem[out_wr] <= core_out_data;
      if (in_push)  in_mem[in_wr]   <= host_rx_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_wr    <= '0;
         out_rd    <= '0;
         out_count <= '0;
      end else begin
         if (out_push) out_wr <= out_wr + 1'b1;
         if (out_pop)  out_rd <= out_rd + 1'b1;
         case ({out_push, out_pop})
            2'b10:   out_count <= out_count + 1'b1;
            2'b01:   out_count <= out_count - 1'b1;
            default: out_count <= out_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_wr    <= '0;
         in_rd    <= '0;
         in_count <= '0;
      end else begin
         if (in_push) in_wr <= in_wr + 1'b1;
         if (in_pop)  in_rd <= in_rd + 1'b1;
         case ({in_push, in_pop})
            2'b10:   in_count <= in_count + 1'b1;
            2'b01:   in_count <= in_count - 1'b1;
            default: in_count <= in_count;
         endcase
      end
   end

   // HOLD waits for the request to drop so each ',' yields exactly one byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         core_in_data <= 8'h00;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_pop) begin
                  core_in_data <= in_mem[in_rd];
                  state        <= S_GRANT;
               end else if (in_eof_load) begin
                  core_in_data <= EOF_BYTE;
                  state        <= S_GRANT;
               end
            end
            S_GRANT: state <= S_HOLD;
            S_HOLD:  if (!core_in_req) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bf_io_port.sv
// Directed self-checking bench for bf_io_port (DEPTH=4).
module tb_bf_io_port;

   logic       clk = 1'b0;
   logic       rst;
   logic       core_out_valid;
   logic [7:0] core_out_data;
   logic       core_out_ready;
   logic       core_in_req;
   logic       core_in_valid;
   logic [7:0] core_in_data;
   logic       host_tx_valid;
   logic [7:0] host_tx_data;
   logic       host_tx_ready;
   logic       host_rx_valid;
   logic [7:0] host_rx_data;
   logic       host_rx_ready;
   logic       host_eof;
   logic [2:0] out_count;
   logic [2:0] in_count;

   int n_checks = 0;
   int n_errors = 0;

   bf_io_port #(.DEPTH(4), .AW(2), .EOF_BYTE(8'hFF)) dut (
      .clk            (clk),
      .rst            (rst),
      .core_out_valid (core_out_valid),
      .core_out_data  (core_out_data),
      .core_out_ready (core_out_ready),
      .core_in_req    (core_in_req),
      .core_in_valid  (core_in_valid),
      .core_in_data   (core_in_data),
      .host_tx_valid  (host_tx_valid),
      .host_tx_data   (host_tx_data),
      .host_tx_ready  (host_tx_ready),
      .host_rx_valid  (host_rx_valid),
      .host_rx_data   (host_rx_data),
      .host_rx_ready  (host_rx_ready),
      .host_eof       (host_eof),
      .out_count      (out_count),
      .in_count       (in_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One ',' transaction from IDLE; returns to IDLE before exiting.
   task automatic read_byte(output logic [7:0] b);
      logic got;
      got = 1'b0;
      b = 8'h00;
      core_in_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (core_in_valid) begin
            got = 1'b1;
            b = core_in_data;
            break;
         end
      end
      check("rd_timeout", 32'(got), 1);
      core_in_req = 1'b0;
      step();
      step();
   endtask

   task automatic host_push(input logic [7:0] d);
      host_rx_valid = 1'b1;
      host_rx_data  = d;
      step();
      host_rx_valid = 1'b0;
   endtask

   logic [7:0] b;
   logic [7:0] fill_bytes [0:4];
   logic [7:0] drain_exp  [0:4];
   int         drain_cnt  [0:4];
   int         pulses;
   int         n;

   initial begin
      fill_bytes = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
      drain_exp  = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
      drain_cnt  = '{3, 3, 2, 1, 0};

      rst = 1'b1;
      core_out_valid = 1'b0; core_out_data = 8'h00;
      core_in_req = 1'b0; host_tx_ready = 1'b0;
      host_rx_valid = 1'b0; host_rx_data = 8'h00; host_eof = 1'b0;
      step(); step();
      check("rst_out_count", 32'(out_count), 0);
      check("rst_in_count", 32'(in_count), 0);
      check("rst_in_valid", 32'(core_in_valid), 0);
      check("rst_in_data", 32'(core_in_data), 0);
      check("rst_tx_valid", 32'(host_tx_valid), 0);
      check("rst_out_ready", 32'(core_out_ready), 1);
      check("rst_rx_ready", 32'(host_rx_ready), 1);
      rst = 1'b0;
      step();

      // Reset with pending output data, asserted mid-cycle
      core_out_valid = 1'b1; core_out_data = 8'hAA; step();
      core_out_data = 8'hBB; step();
      core_out_valid = 1'b0;
      check("pend_count", 32'(out_count), 2);
      check("pend_head", 32'(host_tx_data), 'hAA);
      #2 rst = 1'b1;
      #1;
      check("async_out_count", 32'(out_count), 0);
      check("async_tx_valid", 32'(host_tx_valid), 0);
      step();
      rst = 1'b0;
      check("post_rst_ready", 32'(core_out_ready), 1);
      step();

      // Output fill with host stalled, then drain
      for (int i = 0; i < 4; i++) begin
         core_out_valid = 1'b1; core_out_data = fill_bytes[i];
         check("fill_ready", 32'(core_out_ready), 1);
         step();
      end
      check("full_count", 32'(out_count), 4);
      check("full_ready", 32'(core_out_ready), 0);
      core_out_data = fill_bytes[4];
      step();
      check("refused_count", 32'(out_count), 4);
      host_tx_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("drain_valid", 32'(host_tx_valid), 1);
         check("drain_data", 32'(host_tx_data), 32'(drain_exp[i]));
         if (i == 0) check("drain_ready0", 32'(core_out_ready), 0);
         if (i == 1) check("drain_ready1", 32'(core_out_ready), 1);
         step();
         if (i == 1) core_out_valid = 1'b0;
         check("drain_count", 32'(out_count), 32'(drain_cnt[i]));
      end
      check("drain_empty", 32'(host_tx_valid), 0);
      host_tx_ready = 1'b0;

      // Input request held on an empty FIFO
      core_in_req = 1'b1;
      step();
      check("empty_no_pulse", 32'(core_in_valid), 0);
      host_push(8'h41);
      check("edgeN_no_pulse", 32'(core_in_valid), 0);
      check("edgeN_in_count", 32'(in_count), 1);
      step();
      check("grant_valid", 32'(core_in_valid), 1);
      check("grant_data", 32'(core_in_data), 'h41);
      check("grant_in_count", 32'(in_count), 0);
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (core_in_valid) pulses++;
      end
      check("held_extra_pulses", 32'(pulses), 0);
      check("held_data", 32'(core_in_data), 'h41);
      core_in_req = 1'b0;
      step();

      // EOF on empty FIFO, then no-EOF empty request
      host_eof = 1'b1; core_in_req = 1'b1;
      step();
      check("eof_valid", 32'(core_in_valid), 1);
      check("eof_data", 32'(core_in_data), 'hFF);
      core_in_req = 1'b0; host_eof = 1'b0;
      step();
      check("eof_pulse_end", 32'(core_in_valid), 0);
      step();
      core_in_req = 1'b1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (core_in_valid) pulses++;
      end
      check("noeof_pulses", 32'(pulses), 0);
      core_in_req = 1'b0;
      step();

      // Full input FIFO with simultaneous host offer and core pop
      for (int i = 0; i < 4; i++) host_push(8'(8'h10 + i));
      check("in_full_count", 32'(in_count), 4);
      check("in_full_ready", 32'(host_rx_ready), 0);
      host_rx_valid = 1'b1; host_rx_data = 8'h14; core_in_req = 1'b1;
      step();
      check("sim_pop_valid", 32'(core_in_valid), 1);
      check("sim_pop_data", 32'(core_in_data), 'h10);
      check("sim_refused_count", 32'(in_count), 3);
      core_in_req = 1'b0;
      step();
      host_rx_valid = 1'b0;
      check("sim_accept_count", 32'(in_count), 4);
      step();
      for (int i = 0; i < 4; i++) begin
         read_byte(b);
         check("sim_drain_data", 32'(b), 32'(8'h11 + i));
      end
      check("sim_drain_count", 32'(in_count), 0);

      // Output pointer wrap: 10 bytes streamed at full rate
      host_tx_ready = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         core_out_valid = (i < 10);
         core_out_data  = 8'(i);
         if (i > 0) begin
            check("wrap_tx_valid", 32'(host_tx_valid), 1);
            check("wrap_tx_data", 32'(host_tx_data), 32'(i - 1));
         end
         step();
         check("wrap_out_max", 32'(out_count <= 3'd4), 1);
      end
      core_out_valid = 1'b0; host_tx_ready = 1'b0;
      check("wrap_out_final", 32'(out_count), 0);

      // Input pointer wrap: 10 bytes in chunks of up to 3
      for (int base = 0; base < 10; base += 3) begin
         n = (10 - base < 3) ? 10 - base : 3;
         for (int k = 0; k < n; k++) host_push(8'(base + k));
         check("wrap_in_count", 32'(in_count), 32'(n));
         for (int k = 0; k < n; k++) begin
            read_byte(b);
            check("wrap_in_data", 32'(b), 32'(base + k));
         end
      end
      check("wrap_in_final", 32'(in_count), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/bf_io_port.md
# bf_io_port

Byte-stream I/O port between the bf core and the host side. It buffers bytes the core emits on `.` into an output FIFO drained by the host. It also buffers host-supplied bytes into an input FIFO that answers the core's `,` requests. It replaces the bench-driven `input_data` / `output_data` path so the core runs from a streaming source and sink.

## Interface
- `DEPTH`, 4: entries per FIFO; power of two, ≥2.
- `AW`, 2: log2(DEPTH).
- `EOF_BYTE`, 8'hFF: byte returned to the core on a request when the input FIFO is empty and `host_eof`=1.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `core_out_valid`  in  1  core presents an output byte (`.`).
- `core_out_data`  in  8  output byte.
- `core_out_ready`  out  1  byte accepted this cycle when both valid and ready are 1.
- `core_in_req`  in  1  core in input state (`,`); held until served.
- `core_in_valid`  out  1  one-cycle pulse; `core_in_data` is valid.
- `core_in_data`  out  8  input byte, registered; holds its value between pulses.
- `host_tx_valid`  out  1  output FIFO non-empty.
- `host_tx_data`  out  8  head of output FIFO (first-word fall-through).
- `host_tx_ready`  in  1  host pops the head when both valid and ready are 1.
- `host_rx_valid`  in  1  host offers an input byte.
- `host_rx_data`  in  8  offered byte.
- `host_rx_ready`  out  1  input FIFO not full.
- `host_eof`  in  1  host has no further input.
- `out_count`  out  AW+1  output FIFO occupancy.
- `in_count`  out  AW+1  input FIFO occupancy.

## Operation
- Both FIFOs use circular buffers with AW-bit read and write pointers that wrap modulo DEPTH. Occupancy is an AW+1-bit counter, range 0..DEPTH.
- Output path:
  - `core_out_ready` = (`out_count` != DEPTH), combinational.
  - A push occurs on valid&&ready.
  - `host_tx_valid` = (`out_count` != 0). `host_tx_data` = mem[rd_ptr].
- Input path:
  - `host_rx_ready` = (`in_count` != DEPTH).
  - A push occurs on `host_rx_valid`&&`host_rx_ready`.
- Simultaneous push and pop on the same FIFO leaves the count unchanged and advances both pointers.
- When a FIFO is full, a push is refused even if a pop occurs in the same cycle, because ready depends only on the current count.
- Input FSM, three states:
  - IDLE:
    - if `core_in_req` && `in_count`!=0: pop head into `core_in_data`, go to GRANT.
    - else if `core_in_req` && `in_count`==0 && `host_eof`: load `EOF_BYTE`, go to GRANT.
    - otherwise stay in IDLE.
  - GRANT: `core_in_valid`=1 for exactly this cycle, then go to HOLD.
  - HOLD: wait for `core_in_req`=0, then go to IDLE. This guarantees exactly one byte per `,`, even if the core takes several cycles to drop its request.
- A host push and a core pop on the input FIFO in the same cycle are both honoured.
- Reset, asynchronous and effective immediately, including mid-transfer:
  - Pointers and counts go to 0; FSM goes to IDLE.
  - `core_in_data`=8'h00, `core_in_valid`=0, `host_tx_valid`=0, `core_out_ready`=1, `host_rx_ready`=1.
  - FIFO memory contents are not reset, but are unobservable because valid=0.

## Timing
- Output: a byte pushed at edge N is visible on `host_tx_data` with `host_tx_valid`=1 after edge N, i.e. latency 1.
- Input: a request seen in IDLE at edge N with data available gives `core_in_valid`=1 in the cycle after edge N. Request-to-data latency is 1 cycle.
- Input with an empty FIFO: the first host byte pushed at edge N is popped at edge N+1 and pulsed after edge N+1, i.e. 2 cycles from the host push.
- Back-to-back `,` requests: minimum 3 cycles per byte (IDLE→GRANT→HOLD→IDLE), assuming `core_in_req` drops in the cycle of the GRANT pulse.
- Full-throughput streaming on the output FIFO: 1 byte/cycle when `host_tx_ready`=1.

## Test plan
- Reset with pending data: push 2 output bytes, assert `rst` mid-cycle → `out_count`=0 and `host_tx_valid`=0 immediately; after release, `core_out_ready`=1.
- Output fill/drain, DEPTH=4, `host_tx_ready`=0: push 8'h48, 8'h65, 8'h6C, 8'h6C → `core_out_ready`=0 and a 5th byte 8'h6F is refused. Then set `host_tx_ready`=1 → host receives 48,65,6C,6C in order; 8'h6F is accepted the cycle after the first pop.
- Input request on an empty FIFO: hold `core_in_req`; push 8'h41 at edge N → one `core_in_valid` pulse after edge N+1 with `core_in_data`=8'h41. Holding `core_in_req` for 5 more cycles yields no second pulse.
- EOF: empty FIFO, `host_eof`=1, `core_in_req`=1 → pulse with `core_in_data`=8'hFF one cycle later. With `host_eof`=0 and the FIFO empty, there is no pulse.
- Simultaneous activity: `in_count`=DEPTH, host offering a byte, core request popping in the same cycle → push refused that cycle, accepted next cycle, `in_count` returns to DEPTH.
- Pointer wrap: stream 10 bytes 8'h00..8'h09 through each FIFO, DEPTH=4 → order preserved, counts never exceed 4, final counts 0.
